// File: rtl/branch_predict_ctrl_if.sv
// Fetch/decode-side signal bundle for the branch direction predictor.
// master = pipeline (IF/ID) side, slave = predictor.
interface branch_predict_ctrl_if;
  logic [31:0] IF_PC;
  logic        IF_Valid;
  logic        Pred_Taken;
  logic        ID_Valid;
  logic [31:0] ID_PC;
  logic        ID_JorB;
  logic        ID_Taken;
  logic        ID_PredTaken;
  logic [31:0] ID_AltPC;
  logic [31:0] ID_FallThruPC;
  logic        ID_Freeze;
  logic        Redirect;
  logic [31:0] Redirect_PC;
  logic        Flush_IF;
  logic [31:0] Branch_Count;
  logic [31:0] Mispredict_Count;

  modport master (
    output IF_PC, IF_Valid,
    output ID_Valid, ID_PC, ID_JorB, ID_Taken,
    output ID_PredTaken, ID_AltPC, ID_FallThruPC,
    output ID_Freeze,
    input  Pred_Taken, Redirect, Redirect_PC,
    input  Flush_IF, Branch_Count, Mispredict_Count
  );

  modport slave (
    input  IF_PC, IF_Valid,
    input  ID_Valid, ID_PC, ID_JorB, ID_Taken,
    input  ID_PredTaken, ID_AltPC, ID_FallThruPC,
    input  ID_Freeze,
    output Pred_Taken, Redirect, Redirect_PC,
    output Flush_IF, Branch_Count, Mispredict_Count
  );
endinterface

// File: rtl/branch_predict_ctrl.sv
// 2-bit saturating-counter direction predictor with
// mispredict redirect and IF flush sequencing.
module branch_predict_ctrl #(
  parameter int         IDX_BITS     = 6,
  parameter int         FLUSH_CYCLES = 1,
  parameter logic [1:0] CTR_INIT     = 2'b01
) (
  input logic                 CLK,
  input logic                 RESET,
  branch_predict_ctrl_if.slave bus
);

  localparam int DEPTH = 2 ** IDX_BITS;
  localparam logic [2:0] FLUSH_LAST =
    3'(FLUSH_CYCLES - 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [1:0]  ctr_q [DEPTH];
  logic        redir_q;
  logic [31:0] rpc_q;
  logic        flush_q;
  logic [31:0] bc_q;
  logic [31:0] mc_q;

  logic [IDX_BITS-1:0] if_idx;
  logic [IDX_BITS-1:0] id_idx;
  logic [1:0]  ctr_cur;
  logic [1:0]  ctr_d;
  logic [31:0] rpc_d;
  logic        resolve;
  logic        mispredict;
  logic        unused_pc;

  assign if_idx = bus.IF_PC[IDX_BITS+1:2];
  assign id_idx = bus.ID_PC[IDX_BITS+1:2];
  assign unused_pc = ^{bus.IF_PC[31:IDX_BITS+2],
                       bus.IF_PC[1:0],
                       bus.ID_PC[31:IDX_BITS+2],
                       bus.ID_PC[1:0]};

  // ID inputs during a flush belong to the wrong path
  assign resolve = (state_q == IDLE) & bus.ID_Valid
                 & bus.ID_JorB & ~bus.ID_Freeze;
  assign mispredict = resolve
                    & (bus.ID_Taken != bus.ID_PredTaken);

  assign rpc_d = bus.ID_Taken ? bus.ID_AltPC
                              : bus.ID_FallThruPC;

  always_comb begin
    ctr_cur = ctr_q[id_idx];
    ctr_d   = ctr_cur;
    if (bus.ID_Taken) begin
      if (ctr_cur != 2'd3) ctr_d = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'd0) ctr_d = ctr_cur - 2'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      redir_q <= 1'b0;
      rpc_q   <= 32'd0;
      flush_q <= 1'b0;
      bc_q    <= 32'd0;
      mc_q    <= 32'd0;
      for (int i = 0; i < DEPTH; i++)
        ctr_q[i] <= CTR_INIT;
    end else begin
      redir_q <= 1'b0;
      if (resolve) begin
        ctr_q[id_idx] <= ctr_d;
        bc_q <= bc_q + 32'd1;
      end
      unique case (state_q)
        IDLE: begin
          if (mispredict) begin
            state_q <= FLUSH;
            cnt_q   <= FLUSH_LAST;
            redir_q <= 1'b1;
            rpc_q   <= rpc_d;
            flush_q <= 1'b1;
            mc_q    <= mc_q + 32'd1;
          end
        end
        FLUSH: begin
          if (cnt_q == 3'd0) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // no bypass: same-cycle training shows up next cycle
  assign bus.Pred_Taken = ctr_q[if_idx][1] & bus.IF_Valid;
  assign bus.Redirect         = redir_q;
  assign bus.Redirect_PC      = rpc_q;
  assign bus.Flush_IF         = flush_q;
  assign bus.Branch_Count     = bc_q;
  assign bus.Mispredict_Count = mc_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Bench for branch_predict_ctrl: directed scenarios plus
// randomized traffic against a table-of-ints reference model.
module tb_branch_predict_ctrl;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  branch_predict_ctrl_if b1 ();
  branch_predict_ctrl_if b3 ();

  branch_predict_ctrl dut (
    .CLK(CLK), .RESET(RESET), .bus(b1));
  branch_predict_ctrl #(.FLUSH_CYCLES(3)) dut3 (
    .CLK(CLK), .RESET(RESET), .bus(b3));

  int n_tests = 0;
  int n_fail  = 0;

  // reference model for b1 (FLUSH_CYCLES = 1)
  localparam int FLUSH = 1;
  int          m_ctr [64];
  int          m_bc, m_mc, m_left;
  bit          m_redir;
  logic [31:0] m_rpc;

  function automatic int idx(logic [31:0] pc);
    return (pc >> 2) % 64;
  endfunction

  function automatic bit mpred(logic [31:0] pc, bit v);
    return v && (m_ctr[idx(pc)] >= 2);
  endfunction

  task automatic model_reset();
    foreach (m_ctr[i]) m_ctr[i] = 1;
    m_bc = 0; m_mc = 0; m_left = 0;
    m_redir = 0; m_rpc = 32'd0;
  endtask

  task automatic model_edge();
    m_redir = 0;
    if (m_left > 0) begin
      m_left--;
    end else if (b1.ID_Valid && b1.ID_JorB && !b1.ID_Freeze) begin
      int k;
      k = idx(b1.ID_PC);
      if (b1.ID_Taken) m_ctr[k] = (m_ctr[k] < 3) ? m_ctr[k] + 1 : 3;
      else             m_ctr[k] = (m_ctr[k] > 0) ? m_ctr[k] - 1 : 0;
      m_bc++;
      if (b1.ID_Taken != b1.ID_PredTaken) begin
        m_mc++;
        m_redir = 1;
        m_rpc = b1.ID_Taken ? b1.ID_AltPC : b1.ID_FallThruPC;
        m_left = FLUSH;
      end
    end
  endtask

  task automatic id_set(bit v, bit jb, bit t, bit pt,
                        logic [31:0] pc, logic [31:0] alt,
                        logic [31:0] ft, bit frz);
    b1.ID_Valid = v; b1.ID_JorB = jb;
    b1.ID_Taken = t; b1.ID_PredTaken = pt;
    b1.ID_PC = pc; b1.ID_AltPC = alt;
    b1.ID_FallThruPC = ft; b1.ID_Freeze = frz;
  endtask

  task automatic id_idle();
    id_set(0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 0);
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    model_reset();
    #3;
    RESET = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    b1.IF_PC = 32'h400000; b1.IF_Valid = 1'b1;
    id_idle();
    b3.IF_PC = 32'd0; b3.IF_Valid = 1'b0;
    b3.ID_Valid = 0; b3.ID_JorB = 0; b3.ID_Taken = 0;
    b3.ID_PredTaken = 0; b3.ID_PC = 0; b3.ID_AltPC = 0;
    b3.ID_FallThruPC = 0; b3.ID_Freeze = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    n_tests++; if (b1.Pred_Taken !== 1'b0) begin n_fail++;
      $display("FAIL reset_pred act=%0h exp=0", b1.Pred_Taken); end
    n_tests++; if (b1.Redirect !== 1'b0) begin n_fail++;
      $display("FAIL reset_redirect act=%0h exp=0", b1.Redirect); end
    n_tests++; if (b1.Redirect_PC !== 32'd0) begin n_fail++;
      $display("FAIL reset_rpc act=%0h exp=0", b1.Redirect_PC); end
    n_tests++; if (b1.Flush_IF !== 1'b0) begin n_fail++;
      $display("FAIL reset_flush act=%0h exp=0", b1.Flush_IF); end
    n_tests++; if (b1.Branch_Count !== 32'd0) begin n_fail++;
      $display("FAIL reset_bc act=%0h exp=0", b1.Branch_Count); end
    n_tests++; if (b1.Mispredict_Count !== 32'd0) begin n_fail++;
      $display("FAIL reset_mc act=%0h exp=0", b1.Mispredict_Count); end
    RESET = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_mispredict();
    id_set(1, 1, 1, 0, 32'h400010, 32'h400100, 32'h400018, 0);
    tick();
    n_tests++; if (b1.Redirect !== 1'b1) begin n_fail++;
      $display("FAIL mp_redirect act=%0h exp=1", b1.Redirect); end
    n_tests++; if (b1.Redirect_PC !== 32'h400100) begin n_fail++;
      $display("FAIL mp_rpc act=%0h exp=400100", b1.Redirect_PC); end
    n_tests++; if (b1.Flush_IF !== 1'b1) begin n_fail++;
      $display("FAIL mp_flush act=%0h exp=1", b1.Flush_IF); end
    n_tests++; if (b1.Mispredict_Count !== 32'd1) begin n_fail++;
      $display("FAIL mp_mc act=%0h exp=1", b1.Mispredict_Count); end
    n_tests++; if (b1.Branch_Count !== 32'd1) begin n_fail++;
      $display("FAIL mp_bc act=%0h exp=1", b1.Branch_Count); end
    id_idle();
    tick();
    n_tests++; if (b1.Redirect !== 1'b0 || b1.Flush_IF !== 1'b0) begin n_fail++;
      $display("FAIL mp_drop act=%0h/%0h exp=0/0", b1.Redirect, b1.Flush_IF); end
    n_tests++; if (b1.Redirect_PC !== 32'h400100) begin n_fail++;
      $display("FAIL mp_rpc_hold act=%0h exp=400100", b1.Redirect_PC); end
  endtask

  task automatic test_train();
    bit exp_pred [3] = '{0, 1, 1};
    bit exp_redir [3] = '{1, 0, 0};
    do_reset();
    b1.IF_PC = 32'h400010; b1.IF_Valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (b1.Pred_Taken !== exp_pred[i]) begin n_fail++;
        $display("FAIL train_pred%0d act=%0h exp=%0h", i, b1.Pred_Taken, exp_pred[i]); end
      id_set(1, 1, 1, exp_pred[i], 32'h400010, 32'h400100, 32'h400018, 0);
      tick();
      n_tests++; if (b1.Redirect !== exp_redir[i]) begin n_fail++;
        $display("FAIL train_redir%0d act=%0h exp=%0h", i, b1.Redirect, exp_redir[i]); end
      id_idle();
      tick();
    end
    n_tests++; if (b1.Pred_Taken !== 1'b1) begin n_fail++;
      $display("FAIL train_sat_pred act=%0h exp=1", b1.Pred_Taken); end
    id_set(1, 1, 0, 1, 32'h400010, 32'h400100, 32'h400018, 0);
    tick();
    n_tests++; if (b1.Redirect !== 1'b1 || b1.Redirect_PC !== 32'h400018) begin n_fail++;
      $display("FAIL train_nt_rpc act=%0h/%0h exp=1/400018", b1.Redirect, b1.Redirect_PC); end
    id_idle();
    tick();
    n_tests++; if (b1.Pred_Taken !== 1'b1) begin n_fail++;
      $display("FAIL train_ctr2_pred act=%0h exp=1", b1.Pred_Taken); end
    n_tests++; if (b1.Branch_Count !== 32'd4 || b1.Mispredict_Count !== 32'd2) begin n_fail++;
      $display("FAIL train_counts act=%0d/%0d exp=4/2", b1.Branch_Count, b1.Mispredict_Count); end
  endtask

  task automatic test_flush_multi();
    int redirs = 0;
    int flushes = 0;
    b3.ID_Valid = 1; b3.ID_JorB = 1; b3.ID_Taken = 1;
    b3.ID_PredTaken = 0; b3.ID_PC = 32'h400020;
    b3.ID_AltPC = 32'h400200; b3.ID_FallThruPC = 32'h400028;
    for (int i = 0; i < 5; i++) begin
      tick();
      redirs += int'(b3.Redirect);
      flushes += int'(b3.Flush_IF);
      b3.ID_Taken = ~b3.ID_Taken;
      b3.ID_PredTaken = ~b3.ID_Taken;
      b3.ID_PC = b3.ID_PC + 32'd4;
      if (i == 3) b3.ID_Valid = 0;
    end
    n_tests++; if (flushes != 3) begin n_fail++;
      $display("FAIL flush3_len act=%0d exp=3", flushes); end
    n_tests++; if (redirs != 1) begin n_fail++;
      $display("FAIL flush3_redirs act=%0d exp=1", redirs); end
    n_tests++; if (b3.Redirect_PC !== 32'h400200) begin n_fail++;
      $display("FAIL flush3_rpc act=%0h exp=400200", b3.Redirect_PC); end
    n_tests++; if (b3.Branch_Count !== 32'd1 || b3.Mispredict_Count !== 32'd1) begin n_fail++;
      $display("FAIL flush3_counts act=%0d/%0d exp=1/1", b3.Branch_Count, b3.Mispredict_Count); end
  endtask

  task automatic test_freeze();
    int bc0;
    bc0 = m_bc;
    b1.IF_PC = 32'h400040;
    id_set(1, 1, 1, 0, 32'h400040, 32'h400300, 32'h400048, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++; if (b1.Branch_Count !== 32'(bc0) || b1.Redirect !== 1'b0) begin n_fail++;
        $display("FAIL freeze_hold%0d act=%0d/%0h exp=%0d/0", i, b1.Branch_Count, b1.Redirect, bc0); end
    end
    b1.ID_Freeze = 0;
    tick();
    n_tests++; if (b1.Branch_Count !== 32'(bc0 + 1) || b1.Redirect !== 1'b1) begin n_fail++;
      $display("FAIL freeze_release act=%0d/%0h exp=%0d/1", b1.Branch_Count, b1.Redirect, bc0 + 1); end
    id_idle();
    tick();
    id_set(1, 1, 0, 1, 32'h400040, 32'h400300, 32'h400048, 0);
    tick();
    id_idle();
    tick();
    n_tests++; if (b1.Pred_Taken !== 1'b0) begin n_fail++;
      $display("FAIL freeze_trained_once act=%0h exp=0", b1.Pred_Taken); end
  endtask

  task automatic test_reset_flush();
    id_set(1, 1, 1, 0, 32'h400010, 32'h400100, 32'h400018, 0);
    tick();
    n_tests++; if (b1.Flush_IF !== 1'b1) begin n_fail++;
      $display("FAIL rstfl_pre act=%0h exp=1", b1.Flush_IF); end
    #2;
    RESET = 1'b0;
    model_reset();
    b1.IF_PC = 32'h400010;
    #1;
    n_tests++; if (b1.Flush_IF !== 1'b0 || b1.Redirect !== 1'b0) begin n_fail++;
      $display("FAIL rstfl_drop act=%0h/%0h exp=0/0", b1.Flush_IF, b1.Redirect); end
    n_tests++; if (b1.Pred_Taken !== 1'b0 || b1.Branch_Count !== 32'd0) begin n_fail++;
      $display("FAIL rstfl_table act=%0h/%0d exp=0/0", b1.Pred_Taken, b1.Branch_Count); end
    RESET = 1'b1;
    id_idle();
    b1.IF_PC = 32'h400110;
    tick();
    n_tests++; if (b1.Pred_Taken !== 1'b0) begin n_fail++;
      $display("FAIL alias_before act=%0h exp=0", b1.Pred_Taken); end
    id_set(1, 1, 1, 0, 32'h400010, 32'h400100, 32'h400018, 0);
    tick();
    id_idle();
    tick();
    n_tests++; if (b1.Pred_Taken !== 1'b1) begin n_fail++;
      $display("FAIL alias_after act=%0h exp=1", b1.Pred_Taken); end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    for (int i = 0; i < 400; i++) begin
      b1.IF_Valid = ($urandom_range(0, 7) != 0);
      b1.IF_PC = 32'h400000 + 32'($urandom_range(0, 255)) * 4;
      pc = 32'h400000 + 32'($urandom_range(0, 15)) * 64
         + 32'($urandom_range(0, 3)) * 4;
      id_set($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
             1'($urandom), 1'($urandom), pc, $urandom, $urandom,
             $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 1) == 1)
        b1.ID_PredTaken = mpred(pc, 1);
      #1;
      n_tests++; if (b1.Pred_Taken !== mpred(b1.IF_PC, b1.IF_Valid)) begin n_fail++;
        $display("FAIL rnd_pred c%0d act=%0h exp=%0h", i, b1.Pred_Taken, mpred(b1.IF_PC, b1.IF_Valid)); end
      tick();
      n_tests++; if (b1.Redirect !== m_redir || b1.Redirect_PC !== m_rpc) begin n_fail++;
        $display("FAIL rnd_redir c%0d act=%0h/%0h exp=%0h/%0h", i, b1.Redirect, b1.Redirect_PC, m_redir, m_rpc); end
      n_tests++; if (b1.Flush_IF !== (m_left > 0)) begin n_fail++;
        $display("FAIL rnd_flush c%0d act=%0h exp=%0h", i, b1.Flush_IF, m_left > 0); end
      n_tests++; if (b1.Branch_Count !== 32'(m_bc) || b1.Mispredict_Count !== 32'(m_mc)) begin n_fail++;
        $display("FAIL rnd_counts c%0d act=%0d/%0d exp=%0d/%0d", i, b1.Branch_Count, b1.Mispredict_Count, m_bc, m_mc); end
    end
    id_idle();
  endtask

  initial begin
    test_reset();
    test_mispredict();
    test_train();
    test_flush_multi();
    test_freeze();
    test_reset_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
